// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package codec_cfg_pkg;

   // Byte-level I2C engine commands
   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_START = 2'b01,
      OP_WRITE = 2'b10,
      OP_STOP  = 2'b11
   } eng_op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_CMD_START,
      S_CMD_BYTE,
      S_CMD_STOP,
      S_WAIT,
      S_NEXT,
      S_READY,
      S_FAIL,
      S_ERROR
   } seq_state_e;

   // err_index value reported when a runtime (non-table) write fails
   localparam logic [5:0] RUNTIME_IDX = 6'h3F;

   // WM8731-style codec register addresses
   localparam logic [6:0] REG_LLIN   = 7'h00;
   localparam logic [6:0] REG_RLIN   = 7'h01;
   localparam logic [6:0] REG_LHP    = 7'h02;
   localparam logic [6:0] REG_RHP    = 7'h03;
   localparam logic [6:0] REG_APATH  = 7'h04;
   localparam logic [6:0] REG_DPATH  = 7'h05;
   localparam logic [6:0] REG_PWR    = 7'h06;
   localparam logic [6:0] REG_IFACE  = 7'h07;
   localparam logic [6:0] REG_ACTIVE = 7'h09;
   localparam logic [6:0] REG_RESET  = 7'h0F;

   // Codec write word: 7-bit register address above 9-bit data
   function automatic logic [15:0] cfg_word(input logic [6:0] ra, input logic [8:0] d);
      return {ra, d};
   endfunction

endpackage

// File: rtl/codec_cfg_sequencer_rom.sv
// Init table: maps a table index to a {reg[6:0], data[8:0]} codec write.
// Latency: combinational.
// Backpressure: none.
module codec_init_rom
   import codec_cfg_pkg::*;
(
   input  logic [5:0]  index,
   output logic [15:0] word
);

   // Table lookup; indices past the populated entries read as zero
   always_comb begin
      word = 16'h0000;
      case (index)
         6'd0:    word = cfg_word(REG_RESET,  9'h000);
         6'd1:    word = cfg_word(REG_PWR,    9'h000);
         6'd2:    word = cfg_word(REG_LLIN,   9'h017);
         6'd3:    word = cfg_word(REG_RLIN,   9'h017);
         6'd4:    word = cfg_word(REG_LHP,    9'h179);
         6'd5:    word = cfg_word(REG_RHP,    9'h179);
         6'd6:    word = cfg_word(REG_APATH,  9'h012);
         6'd7:    word = cfg_word(REG_DPATH,  9'h000);
         6'd8:    word = cfg_word(REG_IFACE,  9'h00A);
         6'd9:    word = cfg_word(REG_ACTIVE, 9'h001);
         default: word = 16'h0000;
      endcase
   end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Drives the I2C byte engine through the codec init table, then serves runtime writes.
// Latency: one engine command per cycle issued, then waits for eng_done (bounded by C_TIMEOUT).
// Backpressure: one command outstanding; wr_req held until wr_ack. CFG_RETRY_EN enables NACK retries.
module codec_cfg_sequencer
   import codec_cfg_pkg::*;
#(
   parameter logic [6:0] C_DEV_ADDR  = 7'h1A,
   parameter int         C_NUM_REGS  = 10,
   parameter int         C_TIMEOUT   = 65535,
   parameter int         C_MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       wr_req,
   input  logic [6:0] wr_reg,
   input  logic [8:0] wr_data,
   output logic       wr_ack,
   output logic [1:0] eng_op,
   output logic [7:0] eng_wdata,
   input  logic       eng_done,
   input  logic       eng_nack,
   output logic       init_done,
   output logic       busy,
   output logic       error,
   output logic [5:0] err_index
);

   localparam int         TW       = $clog2(C_TIMEOUT + 1);
   localparam logic [5:0] LAST_IDX = 6'(C_NUM_REGS - 1);

   seq_state_e    state;
   eng_op_e       op_q;
   eng_op_e       last_op;
   logic [5:0]    index;
   logic [1:0]    byte_cnt;
   logic [15:0]   word;
   logic [15:0]   rom_word;
   logic [6:0]    rt_reg;
   logic [8:0]    rt_data;
   logic          runtime;
   logic          nack_seen;
   logic [TW-1:0] timer;
   logic [7:0]    byte_sel;
`ifdef CFG_RETRY_EN
   logic [7:0]    retry;
   logic          timed_out;
`endif

   codec_init_rom u_rom (
      .index (index),
      .word  (rom_word)
   );

   assign eng_op = op_q;
   assign busy   = !(state inside {S_IDLE, S_READY, S_ERROR});

   // Byte to send for the current position within the transaction
   always_comb begin
      byte_sel = {C_DEV_ADDR, 1'b0};
      case (byte_cnt)
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[7:0];
         default: byte_sel = {C_DEV_ADDR, 1'b0};
      endcase
   end

   // Sequencer FSM; all outputs registered, engine command is a one-cycle pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         op_q      <= OP_NOP;
         last_op   <= OP_NOP;
         eng_wdata <= 8'h00;
         wr_ack    <= 1'b0;
         init_done <= 1'b0;
         error     <= 1'b0;
         err_index <= 6'd0;
         index     <= 6'd0;
         byte_cnt  <= 2'd0;
         word      <= 16'h0000;
         rt_reg    <= 7'd0;
         rt_data   <= 9'd0;
         runtime   <= 1'b0;
         nack_seen <= 1'b0;
         timer     <= '0;
`ifdef CFG_RETRY_EN
         retry     <= 8'd0;
         timed_out <= 1'b0;
`endif
      end else begin
         op_q   <= OP_NOP;
         wr_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  index   <= 6'd0;
                  runtime <= 1'b0;
                  state   <= S_FETCH;
               end
            end
            S_FETCH: begin
               word      <= runtime ? {rt_reg, rt_data} : rom_word;
               nack_seen <= 1'b0;
`ifdef CFG_RETRY_EN
               timed_out <= 1'b0;
`endif
               state     <= S_CMD_START;
            end
            S_CMD_START: begin
               op_q    <= OP_START;
               last_op <= OP_START;
               timer   <= '0;
               state   <= S_WAIT;
            end
            S_CMD_BYTE: begin
               op_q      <= OP_WRITE;
               last_op   <= OP_WRITE;
               eng_wdata <= byte_sel;
               timer     <= '0;
               state     <= S_WAIT;
            end
            S_CMD_STOP: begin
               op_q    <= OP_STOP;
               last_op <= OP_STOP;
               timer   <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_done) begin
                  case (last_op)
                     OP_START: begin
                        byte_cnt <= 2'd0;
                        state    <= S_CMD_BYTE;
                     end
                     OP_WRITE: begin
                        if (eng_nack) begin
                           nack_seen <= 1'b1;
                           state     <= S_CMD_STOP;
                        end else if (byte_cnt < 2'd2) begin
                           byte_cnt <= byte_cnt + 2'd1;
                           state    <= S_CMD_BYTE;
                        end else begin
                           state <= S_CMD_STOP;
                        end
                     end
                     default: state <= nack_seen ? S_FAIL : S_NEXT;
                  endcase
               end else if (timer == TW'(C_TIMEOUT)) begin
                  // Engine is unresponsive: abandon without a STOP
`ifdef CFG_RETRY_EN
                  timed_out <= 1'b1;
`endif
                  state <= S_FAIL;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_NEXT: begin
`ifdef CFG_RETRY_EN
               retry <= 8'd0;
`endif
               if (runtime) begin
                  wr_ack <= 1'b1;
                  state  <= S_READY;
               end else if (index == LAST_IDX) begin
                  init_done <= 1'b1;
                  state     <= S_READY;
               end else begin
                  index <= index + 6'd1;
                  state <= S_FETCH;
               end
            end
            S_READY: begin
               // wr_req may still be high in the ack cycle; do not take it twice
               if (wr_req && !wr_ack) begin
                  rt_reg  <= wr_reg;
                  rt_data <= wr_data;
                  runtime <= 1'b1;
                  state   <= S_FETCH;
               end
            end
            S_FAIL: begin
`ifdef CFG_RETRY_EN
               if (nack_seen && !timed_out && retry < 8'(C_MAX_RETRY)) begin
                  retry <= retry + 8'd1;
                  state <= S_FETCH;
               end else
`endif
               begin
                  error     <= 1'b1;
                  err_index <= runtime ? RUNTIME_IDX : index;
                  wr_ack    <= runtime;
                  state     <= S_ERROR;
               end
            end
            default: state <= S_ERROR;
         endcase
      end
   end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Sequences the byte-level I2C engine to configure the audio codec.
- After `start`, walks an init table of C_NUM_REGS register writes, then serves runtime single-register writes (volume, mute) via a req/ack port.
- Each codec write is one transaction: START, device-address byte (7-bit addr + W=0), {reg[6:0],data[8]}, data[7:0], STOP.
- Sits between the codec control top level and the I2C engine.

Parameters:
- C_DEV_ADDR, 7'h1A: codec 7-bit I2C address.
- C_NUM_REGS, 10: init table entries (1..64).
- C_TIMEOUT, 65535: max clk cycles to wait for eng_done per command.
- C_MAX_RETRY, 3: transaction retries on NACK (used only with CFG_RETRY_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins init sequence from IDLE
- wr_req  in  1  runtime write request, held until wr_ack
- wr_reg  in  7  runtime register address
- wr_data  in  9  runtime register data
- wr_ack  out  1  one-cycle pulse when the runtime write's STOP completes (also on abort)
- eng_op  out  2  engine command: 00 NOP, 01 START, 10 WRITE, 11 STOP
- eng_wdata  out  8  byte for WRITE, valid while eng_op==WRITE
- eng_done  in  1  one-cycle pulse; current engine command finished
- eng_nack  in  1  sampled only when eng_done=1 after WRITE
- init_done  out  1  high once init table fully written; sticky until reset
- busy  out  1  high in any state except IDLE, READY, ERROR
- error  out  1  sticky fault flag
- err_index  out  6  table index (or 6'h3F for runtime write) of failing transaction

Behaviour:
- Reset (async assert, sync deassert assumed upstream) values:
  - eng_op=NOP, eng_wdata=0, wr_ack=0, init_done=0, busy=0, error=0, err_index=0, state=IDLE, index=0, byte_cnt=0, retry=0, timer=0.
- Command issue: eng_op is non-NOP for exactly one cycle per command, then NOP while waiting. Only one command is outstanding at a time.
- FSM states:
  - IDLE: on start go to FETCH with index=0. wr_req is ignored in IDLE.
  - FETCH: register the 16-bit word. Init source is the table entry at index; runtime source is {wr_reg, wr_data}. Then go to CMD_START.
  - CMD_START: issue START, then go to WAIT.
  - CMD_BYTE: issue WRITE with the byte selected by byte_cnt:
    - 0: {C_DEV_ADDR,1'b0}
    - 1: word[15:8]
    - 2: word[7:0]
    - Then go to WAIT.
  - CMD_STOP: issue STOP, then go to WAIT.
  - WAIT:
    - On eng_done after START, go to CMD_BYTE with byte_cnt=0.
    - On eng_done after WRITE with no NACK: if byte_cnt<2, increment and go to CMD_BYTE; otherwise go to CMD_STOP.
    - On eng_done after STOP, go to NEXT.
    - NACK on any WRITE: go to CMD_STOP, then FAIL.
  - NEXT:
    - Init mode: if index==C_NUM_REGS-1, set init_done and go to READY; otherwise index++ and go to FETCH.
    - Runtime mode: pulse wr_ack and go to READY.
  - READY: if wr_req, latch wr_reg/wr_data, set runtime mode, go to FETCH. A start pulse in READY is ignored.
  - FAIL: see Optional Feature. Terminal failure sets error, loads err_index, goes to ERROR. A runtime failure also pulses wr_ack.
  - ERROR: terminal until reset. eng_op=NOP; wr_req ignored; no further wr_ack.
- Timeout:
  - timer clears on every command issue and increments in WAIT.
  - If timer reaches C_TIMEOUT, go directly to FAIL with no STOP issued and no retry.
- Simultaneous events:
  - eng_done with eng_nack after START or STOP: nack is ignored.
  - eng_done outside WAIT: ignored.
  - start during busy: ignored.
- Reset mid-transaction: everything returns to reset values immediately. Nothing drives a STOP; bus recovery is the engine's job.

Optional Feature:
- Macro CFG_RETRY_EN.
- Defined:
  - FAIL caused by NACK retries the same transaction from FETCH while retry<C_MAX_RETRY, incrementing retry.
  - retry clears at NEXT.
  - After the retry limit, or on any timeout, the failure is terminal.
- Undefined: every FAIL is terminal. The retry counter and C_MAX_RETRY logic are absent.

Decomposition:
- Package codec_cfg_pkg:
  - eng_op_e enum: NOP/START/WRITE/STOP.
  - seq_state_e enum.
  - RUNTIME_IDX = 6'h3F.
  - Codec register address constants.
- Sub-module codec_init_rom: combinational table, index in, 16-bit word out. Entries are WM8731-style, e.g.
  - entry 0 = reset reg 0x0F = 0x000
  - entry 1 = power-down reg 0x06 = 0x000
  - entry 9 = active reg 0x09 = 0x001

Test Plan:
- Init happy path: start pulse; engine model returns eng_done 4 cycles after each command, never NACKs -> per entry, ops START, WRITE 0x34, WRITE {reg,d8}, WRITE d[7:0], STOP; 50 commands total; init_done=1 after the 10th STOP; busy=0.
- Runtime write: after init, wr_req with wr_reg=0x02, wr_data=0x179 -> bytes 0x34, 0x05, 0x79; wr_ack is exactly one pulse after the STOP's eng_done.
- NACK without CFG_RETRY_EN: NACK on entry 3 byte 1 -> STOP issued, then error=1, err_index=3; no further ops.
- NACK with CFG_RETRY_EN, C_MAX_RETRY=3: NACK on the first 2 attempts of entry 5 -> 3 transactions for entry 5, init_done=1, error=0. With 4 NACKs -> error=1, err_index=5.
- Timeout: C_TIMEOUT=20; engine never answers the first START -> error=1 on cycle 21 of WAIT; eng_op stays NOP; no STOP issued.
- Async reset mid-transfer: drop rst during WAIT for byte 1 of entry 2 -> all outputs return to reset values in the same cycle; a new start re-runs from index 0.
